// File: rtl/nand_reduce_pipe.sv
// Pipelined WIDTH-input AND/NAND/OR/NOR/XOR/XNOR reduction, one registered tree level per stage (LEVELS cycles).
// Backpressure: a single global enable stalls every stage at once; o_ready = ~o_valid | i_ready.
module nand_reduce_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_f,
  output logic             o_op_err
);

  localparam int LEVELS = $clog2(WIDTH);

  function automatic int node_cnt(input int k);
    return (WIDTH + (1 << k) - 1) >> k;
  endfunction

  // Base function only; reserved ops fall into the AND branch.
  function automatic logic base_gate(input logic a, input logic b, input logic [2:0] op);
    logic r;
    case (op[2:1])
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic ident(input logic [2:0] op);
    return !((op[2:1] == 2'b01) || (op[2:1] == 2'b10));
  endfunction

  function automatic logic final_inv(input logic [2:0] op);
    return op[0] & ~(op[2] & op[1]);
  endfunction

  logic en;
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int NI = node_cnt(k - 1);
    localparam int NO = node_cnt(k);

    logic [NI-1:0] src;
    logic [2:0]    src_op;
    logic          src_vld;
    logic [NO-1:0] pair;
    logic [NO-1:0] nxt;
    logic [NO-1:0] node_q;
    logic [2:0]    op_q;
    logic          vld_q;

    if (k == 1) begin : g_head
      assign src     = i_data;
      assign src_op  = i_op;
      assign src_vld = i_valid;
    end else begin : g_body
      assign src     = g_lvl[k-1].node_q;
      assign src_op  = g_lvl[k-1].op_q;
      assign src_vld = g_lvl[k-1].vld_q;
    end

    for (genvar j = 0; j < NO; j++) begin : g_node
      if (2 * j + 1 < NI) begin : g_pair
        assign pair[j] = base_gate(src[2*j], src[2*j+1], src_op);
      end else begin : g_odd
        assign pair[j] = base_gate(src[2*j], ident(src_op), src_op);
      end
    end

    // Inversion happens exactly once, entering the output register.
    if (k == LEVELS) begin : g_tail
      assign nxt = pair ^ {NO{final_inv(src_op)}};
    end else begin : g_mid
      assign nxt = pair;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        node_q <= '0;
        op_q   <= 3'b000;
        vld_q  <= 1'b0;
      end else if (en) begin
        node_q <= nxt;
        op_q   <= src_op;
        vld_q  <= src_vld;
      end
    end
  end

  assign o_valid  = g_lvl[LEVELS].vld_q;
  assign o_f      = g_lvl[LEVELS].node_q[0];
  assign o_op_err = g_lvl[LEVELS].vld_q &
                    ((g_lvl[LEVELS].op_q == 3'b110) | (g_lvl[LEVELS].op_q == 3'b111));

endmodule

// File: tb/tb_nand_reduce_pipe.sv
// Scoreboard bench: WIDTH=4 and WIDTH=5 instances, directed vectors, queued expectations checked by monitors.
module tb_nand_reduce_pipe;

  localparam logic [2:0] AND = 3'b000, NAND = 3'b001, OR = 3'b010, NOR = 3'b011,
                         XOR = 3'b100, XNOR = 3'b101, RSV0 = 3'b110, RSV1 = 3'b111;

  typedef struct {
    logic f;
    logic err;
    int   due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  logic       valid4 = 1'b0, iready4 = 1'b1, ready4, ovalid4, f4, err4;
  logic [3:0] data4 = '0;
  logic [2:0] op4 = '0;
  logic       valid5 = 1'b0, iready5 = 1'b1, ready5, ovalid5, f5, err5;
  logic [4:0] data5 = '0;
  logic [2:0] op5 = '0;

  exp_t q4[$];
  exp_t q5[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nand_reduce_pipe #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid4), .o_ready(ready4), .i_data(data4),
    .i_op(op4), .o_valid(ovalid4), .i_ready(iready4), .o_f(f4), .o_op_err(err4)
  );

  nand_reduce_pipe #(.WIDTH(5)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid5), .o_ready(ready5), .i_data(data5),
    .i_op(op5), .o_valid(ovalid5), .i_ready(iready5), .o_f(f5), .o_op_err(err5)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ovalid4 && iready4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL out4_unexpected: got f=%b err=%b, required no output (cycle %0d)", f4, err4, cyc);
      end else begin
        e = q4.pop_front();
        if (f4 !== e.f || err4 !== e.err || (e.due >= 0 && cyc != e.due)) begin
          errors++;
          $display("FAIL out4: got f=%b err=%b at cycle %0d, required f=%b err=%b due %0d",
                   f4, err4, cyc, e.f, e.err, e.due);
        end
      end
    end
    if (rst_n && ovalid5 && iready5) begin
      checks++;
      if (q5.size() == 0) begin
        errors++;
        $display("FAIL out5_unexpected: got f=%b err=%b, required no output (cycle %0d)", f5, err5, cyc);
      end else begin
        e = q5.pop_front();
        if (f5 !== e.f || err5 !== e.err || (e.due >= 0 && cyc != e.due)) begin
          errors++;
          $display("FAIL out5: got f=%b err=%b at cycle %0d, required f=%b err=%b due %0d",
                   f5, err5, cyc, e.f, e.err, e.due);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send4(input logic [2:0] op, input logic [3:0] d, input logic f, input logic err,
                       input bit lat, input bit push);
    int n = 0;
    valid4 = 1'b1; op4 = op; data4 = d;
    while (!ready4 && n < 50) begin @(negedge clk); n++; end
    if (!ready4) begin
      errors++; checks++;
      $display("FAIL send4_timeout: got o_ready=0, required 1 within 50 cycles");
    end
    if (push) q4.push_back('{f, err, (lat ? cyc + 2 : -1)});
    @(negedge clk);
    valid4 = 1'b0;
  endtask

  task automatic send5(input logic [2:0] op, input logic [4:0] d, input logic f);
    int n = 0;
    valid5 = 1'b1; op5 = op; data5 = d;
    while (!ready5 && n < 50) begin @(negedge clk); n++; end
    if (!ready5) begin
      errors++; checks++;
      $display("FAIL send5_timeout: got o_ready=0, required 1 within 50 cycles");
    end
    q5.push_back('{f, 1'b0, cyc + 3});
    @(negedge clk);
    valid5 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q4.size() != 0 || q5.size() != 0) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (q4.size() != 0 || q5.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending results, required 0", q4.size(), q5.size());
    end
  endtask

  initial begin
    #3;
    check("reset4_outputs", {ovalid4, f4, err4, ready4}, 4'b0001);
    check("reset5_outputs", {ovalid5, f5, err5, ready5}, 4'b0001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // NAND latency and the all-ones boundary
    send4(NAND, 4'b1111, 1'b0, 1'b0, 1, 1);
    send4(NAND, 4'b1110, 1'b1, 1'b0, 1, 1);
    // Interleaved ops on the same operand
    send4(AND,  4'b1011, 1'b0, 1'b0, 1, 1);
    send4(OR,   4'b1011, 1'b1, 1'b0, 1, 1);
    send4(XOR,  4'b1011, 1'b1, 1'b0, 1, 1);
    send4(XNOR, 4'b1011, 1'b0, 1'b0, 1, 1);
    send4(NOR,  4'b1011, 1'b0, 1'b0, 1, 1);
    // Reserved ops reduce as AND and flag only their own word
    send4(RSV0, 4'b1111, 1'b1, 1'b1, 1, 1);
    send4(RSV1, 4'b0111, 1'b0, 1'b1, 1, 1);
    send4(AND,  4'b1111, 1'b1, 1'b0, 1, 1);
    send4(NAND, 4'b0000, 1'b1, 1'b0, 1, 1);
    send4(NOR,  4'b0000, 1'b1, 1'b0, 1, 1);
    send4(XOR,  4'b0110, 1'b0, 1'b0, 1, 1);
    drain();

    // Backpressure: two words fill the pipe, the third waits on o_ready
    iready4 = 1'b0;
    send4(AND, 4'b1111, 1'b1, 1'b0, 0, 1);
    send4(OR,  4'b0000, 1'b0, 1'b0, 0, 1);
    valid4 = 1'b1; op4 = XOR; data4 = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      check("stall_hold", {ready4, ovalid4, f4, err4}, 4'b0110);
      @(negedge clk);
    end
    iready4 = 1'b1;
    q4.push_back('{1'b1, 1'b0, -1});
    @(negedge clk);
    valid4 = 1'b0;
    drain();

    // Odd width: unpaired nodes combine with the identity element
    send5(OR,   5'b10000, 1'b1);
    send5(AND,  5'b11111, 1'b1);
    send5(AND,  5'b01111, 1'b0);
    send5(XOR,  5'b10101, 1'b1);
    send5(XNOR, 5'b00001, 1'b0);
    send5(NOR,  5'b00000, 1'b1);
    send5(NAND, 5'b11110, 1'b1);
    send5(XOR,  5'b10000, 1'b1);
    drain();

    // Asynchronous reset with two words in flight
    send4(AND, 4'b1111, 1'b1, 1'b0, 0, 0);
    valid4 = 1'b1; op4 = OR; data4 = 4'b0001;
    @(posedge clk);
    #2;
    check("pre_reset_valid", {3'b000, ovalid4}, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("async_reset4", {ovalid4, f4, err4, ready4}, 4'b0001);
    valid4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_idle", {3'b000, ovalid4}, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nand_reduce_pipe.md
Name: nand_reduce_pipe

Overview:
- Parametrised, pipelined N-input logic-reduction gate. Generalises the fixed 4-input NAND to WIDTH inputs and selectable gate function: AND/NAND/OR/NOR/XOR/XNOR.
- Implemented as a registered balanced tree of 2-input gates with a valid/ready handshake on both sides.
- Sits between datapath producers and consumers wherever a wide reduction must meet timing at high clock rates.

Parameters:
- WIDTH, 4, number of reduction inputs; legal range 2..64.
- LEVELS, derived as ceil(log2(WIDTH)); not overridable; equals pipeline depth in cycles.

Ports:
- i_clk  input  1  sole clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  upstream has a word on i_data/i_op.
- o_ready  output  1  block can accept a word this cycle.
- i_data  input  WIDTH  operand bits to reduce.
- i_op  input  3  function: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 11x reserved.
- o_valid  output  1  o_f/o_op_err hold a result.
- i_ready  input  1  downstream accepts the result this cycle.
- o_f  output  1  reduction result.
- o_op_err  output  1  result was produced from a reserved i_op.

Behaviour:
- Reset (i_rst_n low, asynchronous): all stage valid bits, o_valid, o_f and o_op_err clear to 0 immediately, independent of i_clk. Tree data registers may also clear. o_ready = 1 while in reset and after release.
- Pipeline:
  - LEVELS register stages; stage k holds ceil(WIDTH/2^k) partial results plus the op and a valid bit.
  - Stage 1 captures the first gate level from i_data. The last stage drives o_f.
- Advance: one global enable, en = ~o_valid | i_ready.
  - All stages shift together when en = 1 and hold when en = 0.
  - o_ready = en, combinational.
  - An accept occurs when i_valid & o_ready; a transfer out occurs when o_valid & i_ready.
  - Bubbles do not collapse; a stalled pipeline holds bubbles in place.
- Latency: a word accepted at edge t appears with o_valid = 1 after edge t+LEVELS-1, i.e. LEVELS cycles of register delay, when no stall occurs. Throughput is one word per cycle.
- Odd counts: an unpaired node at any level is combined with the identity element of the base function: 1 for AND-type, 0 for OR/XOR-type. Results equal the mathematical reduction over exactly WIDTH bits.
- Inversion: NAND/NOR/XNOR are computed as the base AND/OR/XOR tree, inverted once at the final stage only.
- Op carry: i_op is sampled with i_data and travels with its word. Words with different ops may be interleaved back-to-back.
- Reserved op (110/111): reduce as AND, set o_op_err = 1 for that word only. o_op_err = 0 for legal ops.
- Stall while full: o_valid, o_f and o_op_err stay stable until transfer out. No word is lost or duplicated.
- Simultaneous accept and transfer out on the same edge while full: legal, proceeds at full rate.
- i_valid = 0 while en = 1 inserts a bubble; o_valid goes low LEVELS cycles later.
- i_data/i_op are don't-care when i_valid = 0.
- Reset mid-operation: all in-flight words are discarded. After release, o_valid stays 0 until a new accepted word reaches the output.

Test Plan:
- WIDTH=4, i_op=001 NAND, i_data=4'b1111 accepted at cycle 0 -> o_valid=1 at cycle 2, o_f=0. Then 4'b1110 -> o_f=1 one cycle later.
- WIDTH=4, i_ready=1, back-to-back i_data=4'b1011 with ops AND, OR, XOR, XNOR, NOR on cycles 0-4 -> o_f = 0, 1, 1, 0, 0 on consecutive cycles 2-6, o_op_err=0 throughout.
- Backpressure:
  - Stimulus: fill with AND 4'b1111, OR 4'b0000, XOR 4'b0001, then hold i_ready=0 for 3 cycles.
  - Response: o_ready=0, o_f=1 stable, no advance. On i_ready=1 the results 1, 0, 1 emerge in order with none dropped.
- WIDTH=5 (LEVELS=3):
  - OR 5'b10000 -> 1.
  - AND 5'b11111 -> 1.
  - AND 5'b01111 -> 0.
  - XOR 5'b10101 -> 1.
  - XNOR 5'b00001 -> 0.
  - Each result appears 3 cycles after accept.
- i_op=3'b110 with i_data=4'b1111 -> o_f=1, o_op_err=1. The following AND word -> o_op_err=0.
- Reset mid-flight:
  - Stimulus: accept 2 words, drop i_rst_n asynchronously between clock edges.
  - Response: o_valid=0 without a clock edge. After release with i_valid=0 for 4 cycles, o_valid stays 0.
